// File: rtl/pwm_multi_channel_pkg.sv
// pwm_multi_channel_pkg: register map and encodings for the multi-channel PWM
package pwm_multi_channel_pkg;
  localparam int ADDR_PERIOD = 0;
  localparam int ADDR_CTRL = 1;
  localparam int ADDR_CH_EN = 2;
  localparam int ADDR_POL = 3;
  localparam int ADDR_DUTY0 = 4;
  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTRE = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  function automatic int duty_addr(input int ch);
    return ADDR_DUTY0 + ch;
  endfunction
endpackage

// File: rtl/pwm_multi_channel_channel.sv
// pwm_multi_channel_channel: one PWM output with its own shadowed duty compare
module pwm_multi_channel_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             en,
  input  logic             pol,
  input  logic [WIDTH-1:0] duty_pending,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);
  logic [WIDTH-1:0] duty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      duty <= '0;
      pwm <= 1'b0;
    end else begin
      if (load) duty <= duty_pending;
      pwm <= (run && en) ? (cnt < duty) ^ pol : pol;
    end
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared-timebase PWM, edge/centre aligned, with shadow registers
// that are copied into the active set only at a period boundary.
module pwm_multi_channel
  import pwm_multi_channel_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] period_p, period_a, period_n, cnt, cnt_n;
  logic [CHANNELS-1:0] en_p, en_a, pol_p, pol_a;
  logic [WIDTH-1:0] duty_p [CHANNELS];
  mode_e mode_p, mode_a, mode_n;
  dir_e dir, dir_n;
  logic load, run, last, tick_n;
  int wa, ra;
  assign wa = int'(wr_addr);
  assign ra = int'(rd_addr);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      period_p <= '0;
      mode_p <= MODE_EDGE;
      en_p <= '0;
      pol_p <= '0;
      for (int i = 0; i < CHANNELS; i++) duty_p[i] <= '0;
    end else if (wr_en) begin
      if (wa == ADDR_PERIOD) period_p <= wr_data;
      if (wa == ADDR_CTRL) mode_p <= mode_e'(wr_data[0]);
      if (wa == ADDR_CH_EN) en_p <= wr_data[CHANNELS-1:0];
      if (wa == ADDR_POL) pol_p <= wr_data[CHANNELS-1:0];
      for (int i = 0; i < CHANNELS; i++) if (wa == duty_addr(i)) duty_p[i] <= wr_data;
    end
  // While idle the shadow set streams straight through so a restart sees current values
  assign load = period_tick || !enable || period_a == '0;
  assign run = enable && period_a != '0;
  assign last = cnt == period_a - ONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      period_a <= '0;
      mode_a <= MODE_EDGE;
      en_a <= '0;
      pol_a <= '0;
    end else if (load) begin
      period_a <= period_p;
      mode_a <= mode_p;
      en_a <= en_p;
      pol_a <= pol_p;
    end
  // Both modes end a period at count 0 heading up, so a boundary needs no special restart
  always_comb begin
    period_n = load ? period_p : period_a;
    mode_n = load ? mode_p : mode_a;
    cnt_n = '0;
    dir_n = DIR_UP;
    if (run) begin
      if (mode_a == MODE_EDGE) cnt_n = last ? '0 : cnt + ONE;
      else if (dir == DIR_UP) begin
        cnt_n = last ? cnt : cnt + ONE;
        dir_n = last ? DIR_DOWN : DIR_UP;
      end else begin
        cnt_n = cnt == '0 ? '0 : cnt - ONE;
        dir_n = cnt == '0 ? DIR_UP : DIR_DOWN;
      end
    end
    tick_n = enable && period_n != '0 &&
             (mode_n == MODE_EDGE ? cnt_n == period_n - ONE : cnt_n == '0 && dir_n == DIR_DOWN);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      dir <= DIR_UP;
      period_tick <= 1'b0;
    end else begin
      cnt <= cnt_n;
      dir <= dir_n;
      period_tick <= tick_n;
    end
  always_comb begin
    rd_data = ra == ADDR_PERIOD ? period_p :
              ra == ADDR_CTRL   ? WIDTH'(mode_p) :
              ra == ADDR_CH_EN  ? WIDTH'(en_p) :
              ra == ADDR_POL    ? WIDTH'(pol_p) : '0;
    for (int i = 0; i < CHANNELS; i++) if (ra == duty_addr(i)) rd_data = duty_p[i];
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_multi_channel_channel #(.WIDTH(WIDTH)) u_ch (
      .clk(clk),
      .reset(reset),
      .load(load),
      .run(run),
      .en(en_a[c]),
      .pol(pol_a[c]),
      .duty_pending(duty_p[c]),
      .cnt(cnt),
      .pwm(pwm_out[c])
    );
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed stimulus with a cycle-stamped expectation queue
module tb_pwm_multi_channel;
  import pwm_multi_channel_pkg::*;
  logic clk = 0, reset = 0, enable = 0, wr_en = 0;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [15:0] wr_data = 0;
  logic [15:0] rd_data;
  logic [3:0] pwm_out;
  logic period_tick;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    int at;
    bit is_tick;
    logic [3:0] mask;
    logic [3:0] val;
    string name;
  } exp_t;
  exp_t q[$];

  pwm_multi_channel #(.CHANNELS(4), .WIDTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.is_tick) check(e.name, {15'b0, period_tick}, {15'b0, e.val[0]});
      else check(e.name, 16'(pwm_out & e.mask), 16'(e.val & e.mask));
    end
  end

  task automatic exp_pwm(input int at, input logic [3:0] mask, input logic [3:0] val, input string name);
    q.push_back('{at, 1'b0, mask, val, name});
  endtask

  task automatic exp_tick(input int at, input logic v, input string name);
    q.push_back('{at, 1'b1, 4'h1, {3'b0, v}, name});
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_addr = 4'(a);
    wr_data = d;
    wr_en = 1;
    @(posedge clk);
    #1 wr_en = 0;
  endtask

  task automatic wait_tick();
    logic seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = period_tick;
    end
    check("tick_seen", {15'b0, seen}, 16'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 16'(q.size()), 16'd0);
  endtask

  task automatic rd_check(input int a, input logic [15:0] exp, input string name);
    rd_addr = 4'(a);
    #1 check(name, rd_data, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w, d;
    logic [15:0] pat;
    #1 reset = 1;
    #11 check("rst_pwm", 16'(pwm_out), 16'd0);
    check("rst_tick", {15'b0, period_tick}, 16'd0);
    rd_check(ADDR_PERIOD, 16'd0, "rst_period");
    @(negedge clk);
    reset = 0;
    // edge mode, P=10, duty 3
    wr(ADDR_PERIOD, 16'd10);
    wr(ADDR_DUTY0, 16'd3);
    wr(ADDR_CH_EN, 16'd1);
    enable = 1;
    wait_tick();
    t = cyc;
    for (int k = 1; k <= 20; k++) begin
      exp_pwm(t + k, 4'h1, 4'(((k + 8) % 10) < 3), "edge_d3");
      exp_tick(t + k, k % 10 == 0, "edge_tick");
    end
    drain();
    // duty extremes, polarity and channel disable
    wr(ADDR_DUTY0, 16'd0);
    wr(ADDR_DUTY0 + 1, 16'd10);
    wr(ADDR_DUTY0 + 2, 16'd15);
    wr(ADDR_DUTY0 + 3, 16'd3);
    wr(ADDR_CH_EN, 16'd7);
    wait_tick();
    t = cyc;
    for (int k = 2; k <= 11; k++) exp_pwm(t + k, 4'hF, 4'b0110, "duty_0_10_15");
    drain();
    wr(ADDR_POL, 16'hF);
    wait_tick();
    t = cyc;
    for (int k = 2; k <= 11; k++) exp_pwm(t + k, 4'hF, 4'b1001, "pol_inv");
    drain();
    wr(ADDR_CH_EN, 16'd0);
    wait_tick();
    t = cyc;
    for (int k = 2; k <= 11; k++) exp_pwm(t + k, 4'hF, 4'b1111, "ch_dis_pol");
    drain();
    // centre mode, P=8, duty 3
    wr(ADDR_POL, 16'd0);
    wr(ADDR_CH_EN, 16'd1);
    wr(ADDR_DUTY0, 16'd3);
    wr(ADDR_PERIOD, 16'd8);
    wr(ADDR_CTRL, 16'd1);
    wait_tick();
    wait_tick();
    t = cyc;
    pat = 16'h801F;
    for (int k = 1; k <= 32; k++) begin
      exp_pwm(t + k, 4'h1, 4'(pat[k % 16]), "centre_d3");
      exp_tick(t + k, k % 16 == 0, "centre_tick");
    end
    drain();
    // duty change mid-period, back in edge mode P=10
    wr(ADDR_CTRL, 16'd0);
    wr(ADDR_PERIOD, 16'd10);
    wait_tick();
    wait_tick();
    t = cyc;
    for (int k = 1; k <= 21; k++) begin
      d = k >= 12 ? 7 : 3;
      exp_pwm(t + k, 4'h1, 4'(((k + 8) % 10) < d), "duty_mid");
      exp_tick(t + k, k % 10 == 0, "tick_mid");
    end
    repeat (4) @(negedge clk);
    wr(ADDR_DUTY0, 16'd7);
    drain();
    // write landing on the tick cycle waits a full extra period
    wait_tick();
    t = cyc;
    for (int k = 1; k <= 21; k++) begin
      d = k >= 12 ? 2 : 7;
      exp_pwm(t + k, 4'h1, 4'(((k + 8) % 10) < d), "duty_on_tick");
      exp_tick(t + k, k % 10 == 0, "tick_on_tick");
    end
    wr(ADDR_DUTY0, 16'd2);
    drain();
    // async reset between edges
    wr(ADDR_DUTY0 + 1, 16'd15);
    wr(ADDR_CH_EN, 16'd3);
    wait_tick();
    wait_tick();
    check("pre_rst_pwm1", {15'b0, pwm_out[1]}, 16'd1);
    #2 reset = 1;
    #1 check("rst_async_pwm", 16'(pwm_out), 16'd0);
    check("rst_async_tick", {15'b0, period_tick}, 16'd0);
    rd_check(ADDR_DUTY0 + 1, 16'd0, "rst_pending_duty");
    repeat (2) @(negedge clk);
    reset = 0;
    // P=0: no ticks, outputs sit at polarity
    wr(ADDR_POL, 16'd5);
    w = cyc;
    for (int k = 3; k <= 20; k++) begin
      exp_pwm(w + k, 4'hF, 4'h5, "p0_pol");
      exp_tick(w + k, 1'b0, "p0_notick");
    end
    drain();
    // P=1 edge: tick every cycle
    wr(ADDR_PERIOD, 16'd1);
    w = cyc;
    for (int k = 3; k <= 12; k++) exp_tick(w + k, 1'b1, "p1_tick");
    drain();
    // disabled: outputs at polarity, no tick; then register readback
    enable = 0;
    wr(ADDR_PERIOD, 16'h1234);
    wr(ADDR_CTRL, 16'hFFFF);
    wr(ADDR_CH_EN, 16'hFFFF);
    wr(ADDR_POL, 16'hFFFA);
    wr(ADDR_DUTY0, 16'h0011);
    wr(ADDR_DUTY0 + 1, 16'h0022);
    wr(ADDR_DUTY0 + 2, 16'h0033);
    wr(ADDR_DUTY0 + 3, 16'h0044);
    wr(15, 16'hBEEF);
    w = cyc;
    for (int k = 3; k <= 10; k++) begin
      exp_pwm(w + k, 4'hF, 4'hA, "dis_pol");
      exp_tick(w + k, 1'b0, "dis_notick");
    end
    rd_check(ADDR_PERIOD, 16'h1234, "rd_period");
    rd_check(ADDR_CTRL, 16'h0001, "rd_ctrl");
    rd_check(ADDR_CH_EN, 16'h000F, "rd_ch_en");
    rd_check(ADDR_POL, 16'h000A, "rd_pol");
    rd_check(ADDR_DUTY0, 16'h0011, "rd_duty0");
    rd_check(ADDR_DUTY0 + 1, 16'h0022, "rd_duty1");
    rd_check(ADDR_DUTY0 + 2, 16'h0033, "rd_duty2");
    rd_check(ADDR_DUTY0 + 3, 16'h0044, "rd_duty3");
    for (int a = 8; a <= 15; a++) rd_check(a, 16'd0, "rd_unmapped");
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
